// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared sizing and requester-index constants for the common data bus
//   arbiter and its round-robin picker.
//   N_REQ    : number of result producers feeding the CDB
//   ROB_ID_W : reorder-buffer tag width
//   DATA_W   : result width
//   REQ_*    : requester slot indices (ALU, load/store buffer, branch unit)
package cdb_arbiter_pkg;

  localparam int N_REQ    = 3;
  localparam int ROB_ID_W = 5;
  localparam int DATA_W   = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LSB  = 1;
  localparam int REQ_BR   = 2;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. Starting at ptr_in and searching
//   upward (wrapping modulo N), selects the first asserted valid_in bit.
//   Ports:
//     valid_in  [N-1:0]     : per-slot occupancy
//     ptr_in    [PTR_W-1:0] : index with highest priority this cycle
//     grant_out [N-1:0]     : one-hot grant, all zero when nothing valid
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N     = N_REQ,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid_in,
  input  logic [PTR_W-1:0] ptr_in,
  output logic [N-1:0]     grant_out
);

  always_comb begin
    int  idx;
    logic found;
    grant_out = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr_in) + off) % N;
      if (!found && valid_in[idx]) begin
        grant_out[idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Common data bus arbiter. Each requester owns a one-entry holding slot;
//   a round-robin picker selects one occupied slot per cycle and its entry
//   is registered onto the CDB outputs at the next edge (2-cycle latency,
//   one broadcast per cycle sustained).
//   Ports:
//     clk_in, rst_in  : clock, synchronous active-high reset
//     rdy_in          : global pause when low (all state holds)
//     _clear          : misprediction flush (empties slots, resets pointer)
//     _req_valid/_req_rob_id/_req_value : per-requester offers (packed)
//     _req_ready      : per-requester accept (combinational)
//     _cdb_ready/_cdb_rob_id/_cdb_value : registered broadcast
module cdb_arbiter #(
  parameter int N_REQ    = cdb_arbiter_pkg::N_REQ,
  parameter int ROB_ID_W = cdb_arbiter_pkg::ROB_ID_W,
  parameter int DATA_W   = cdb_arbiter_pkg::DATA_W
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      _clear,
  input  logic [N_REQ-1:0]          _req_valid,
  input  logic [N_REQ*ROB_ID_W-1:0] _req_rob_id,
  input  logic [N_REQ*DATA_W-1:0]   _req_value,
  output logic [N_REQ-1:0]          _req_ready,
  output logic                      _cdb_ready,
  output logic [ROB_ID_W-1:0]       _cdb_rob_id,
  output logic [DATA_W-1:0]         _cdb_value
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ROB_ID_W-1:0] req_rob_id [N_REQ];
  logic [DATA_W-1:0]   req_value  [N_REQ];

  logic [N_REQ-1:0]    slot_valid_q,  slot_valid_d;
  logic [ROB_ID_W-1:0] slot_rob_id_q [N_REQ];
  logic [ROB_ID_W-1:0] slot_rob_id_d [N_REQ];
  logic [DATA_W-1:0]   slot_value_q  [N_REQ];
  logic [DATA_W-1:0]   slot_value_d  [N_REQ];
  logic [PTR_W-1:0]    rr_ptr_q,      rr_ptr_d;
  logic                cdb_ready_q,   cdb_ready_d;
  logic [ROB_ID_W-1:0] cdb_rob_id_q,  cdb_rob_id_d;
  logic [DATA_W-1:0]   cdb_value_q,   cdb_value_d;

  logic [N_REQ-1:0]    arb_grant;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    accept;
  logic [PTR_W-1:0]    gidx;
  logic                advance;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_rob_id[gi] = _req_rob_id[gi*ROB_ID_W +: ROB_ID_W];
      assign req_value[gi]  = _req_value[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .valid_in  (slot_valid_q),
    .ptr_in    (rr_ptr_q),
    .grant_out (arb_grant)
  );

  // Grants only take effect on an advancing cycle; reset also blocks accepts
  // so nothing is taken in during the cycle it would be discarded.
  assign advance    = rdy_in & ~_clear & ~rst_in;
  assign grant      = arb_grant & {N_REQ{advance}};
  // A granted slot empties at this edge, so it can be refilled in the same cycle.
  assign _req_ready = {N_REQ{advance}} & (~slot_valid_q | grant);
  assign accept     = _req_valid & _req_ready;

  always_comb begin
    gidx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) gidx = PTR_W'(k);
    end
  end

  always_comb begin
    slot_valid_d  = slot_valid_q;
    slot_rob_id_d = slot_rob_id_q;
    slot_value_d  = slot_value_q;
    rr_ptr_d      = rr_ptr_q;
    cdb_ready_d   = cdb_ready_q;
    cdb_rob_id_d  = cdb_rob_id_q;
    cdb_value_d   = cdb_value_q;
    if (_clear) begin
      // Broadcast payload is left as-is; only the valid flag matters downstream.
      slot_valid_d = '0;
      cdb_ready_d  = 1'b0;
      rr_ptr_d     = '0;
    end else if (rdy_in) begin
      cdb_ready_d = |grant;
      if (|grant) begin
        cdb_rob_id_d = slot_rob_id_q[gidx];
        cdb_value_d  = slot_value_q[gidx];
        rr_ptr_d     = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);
      end
      for (int k = 0; k < N_REQ; k++) begin
        if (grant[k]) slot_valid_d[k] = 1'b0;
        // Refill wins over the grant-clear on the same slot.
        if (accept[k]) begin
          slot_valid_d[k]  = 1'b1;
          slot_rob_id_d[k] = req_rob_id[k];
          slot_value_d[k]  = req_value[k];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_ready_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_ready_q  <= cdb_ready_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_value_q  <= cdb_value_d;
    end
  end

  // Slot payloads are qualified by slot_valid_q, so they need no reset.
  always_ff @(posedge clk_in) begin
    slot_rob_id_q <= slot_rob_id_d;
    slot_value_q  <= slot_value_d;
  end

  assign _cdb_ready  = cdb_ready_q;
  assign _cdb_rob_id = cdb_rob_id_q;
  assign _cdb_value  = cdb_value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Directed bench for cdb_arbiter. Expected broadcasts are queued when the
//   offer is driven and popped when the CDB shows a result; control flags,
//   accept flags and frozen/reset output values are checked directly.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NR = N_REQ;
  localparam int IW = ROB_ID_W;
  localparam int DW = DATA_W;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] val;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic              clear = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*IW-1:0]  req_rob_id = '0;
  logic [NR*DW-1:0]  req_value = '0;
  logic [NR-1:0]     req_ready;
  logic              cdb_ready;
  logic [IW-1:0]     cdb_rob_id;
  logic [DW-1:0]     cdb_value;

  int   vectors = 0;
  int   miscompares = 0;
  ent_t sb[$];

  cdb_arbiter #(
    .N_REQ    (NR),
    .ROB_ID_W (IW),
    .DATA_W   (DW)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .rdy_in      (rdy),
    ._clear      (clear),
    ._req_valid  (req_valid),
    ._req_rob_id (req_rob_id),
    ._req_value  (req_value),
    ._req_ready  (req_ready),
    ._cdb_ready  (cdb_ready),
    ._cdb_rob_id (cdb_rob_id),
    ._cdb_value  (cdb_value)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] val_of(input logic [IW-1:0] t);
    return DW'(32'hC0DE_0000 + 32'(t) * 32'h0000_0101);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input int k, input logic [IW-1:0] t, input logic [DW-1:0] v, input bit push);
    req_valid[k]           = 1'b1;
    req_rob_id[k*IW +: IW] = t;
    req_value[k*DW +: DW]  = v;
    if (push) sb.push_back(ent_t'{id: t, val: v});
  endtask

  task automatic sb_push(input logic [IW-1:0] t);
    sb.push_back(ent_t'{id: t, val: val_of(t)});
  endtask

  task automatic expect_bcast(input string tag);
    ent_t e;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL %s_sb observed=broadcast expected=empty_queue", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_rdy"}, 64'(cdb_ready), 64'(1));
      chk({tag, "_id"}, 64'(cdb_rob_id), 64'(e.id));
      chk({tag, "_val"}, 64'(cdb_value), 64'(e.val));
    end
  endtask

  task automatic expect_idle(input string tag);
    chk(tag, 64'(cdb_ready), 64'(0));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // Reset: accepts blocked, outputs cleared.
    req_valid = '1;
    step();
    #1 chk("rst_req_ready", 64'(req_ready), 64'(0));
    step();
    chk("rst_cdb_ready", 64'(cdb_ready), 64'(0));
    chk("rst_cdb_id", 64'(cdb_rob_id), 64'(0));
    chk("rst_cdb_val", 64'(cdb_value), 64'(0));
    rst = 1'b0;
    req_valid = '0;
    step();
    expect_idle("post_rst_idle");

    // Single request, 2-cycle latency.
    offer(REQ_ALU, 5'd3, 32'h1234_5678, 1);
    #1 chk("single_ready", 64'(req_ready), 64'(3'b111));
    step();
    req_valid = '0;
    expect_idle("single_c1");
    step();
    expect_bcast("single_c2");
    step();
    expect_idle("single_c3");

    // Flush an empty arbiter to bring the pointer back to 0.
    clear = 1'b1;
    step();
    clear = 1'b0;

    // Three-way contention from pointer 0.
    offer(REQ_ALU, 5'd10, val_of(5'd10), 1);
    offer(REQ_LSB, 5'd11, val_of(5'd11), 1);
    offer(REQ_BR,  5'd12, val_of(5'd12), 1);
    step();
    req_valid = '0;
    expect_idle("cont_c1");
    #1 chk("cont_ready", 64'(req_ready), 64'(3'b001));
    step();
    expect_bcast("cont_alu");
    step();
    expect_bcast("cont_lsb");
    step();
    expect_bcast("cont_br");
    // Pointer must be back at 0: ALU beats BR.
    offer(REQ_ALU, 5'd13, val_of(5'd13), 1);
    offer(REQ_BR,  5'd14, val_of(5'd14), 1);
    step();
    req_valid = '0;
    expect_idle("cont_gap");
    step();
    expect_bcast("ptr0_alu");
    step();
    expect_bcast("ptr0_br");
    step();
    expect_idle("ptr0_idle");

    // Backpressure: move pointer to 2 with a lone LSB grant, then LSB waits.
    offer(REQ_LSB, 5'd30, val_of(5'd30), 1);
    step();
    req_valid = '0;
    step();
    expect_bcast("bp_pre_lsb");
    offer(REQ_ALU, 5'd20, val_of(5'd20), 0);
    offer(REQ_LSB, 5'd21, val_of(5'd21), 0);
    offer(REQ_BR,  5'd22, val_of(5'd22), 0);
    sb_push(5'd22);
    sb_push(5'd20);
    sb_push(5'd21);
    sb_push(5'd23);
    step();
    req_valid[REQ_BR] = 1'b0;
    expect_idle("bp_c1");
    #1 chk("bp_ready_c1", 64'(req_ready), 64'(3'b100));
    step();
    expect_bcast("bp_br");
    offer(REQ_ALU, 5'd23, val_of(5'd23), 0);
    #1 chk("bp_ready_c2", 64'(req_ready), 64'(3'b101));
    step();
    expect_bcast("bp_alu");
    req_valid = '0;
    #1 chk("bp_ready_c3", 64'(req_ready), 64'(3'b110));
    step();
    expect_bcast("bp_lsb");
    step();
    expect_bcast("bp_alu_refill");
    step();
    expect_idle("bp_idle");

    // Flush with tags 4 and 5 held; a concurrent BR offer is dropped.
    offer(REQ_ALU, 5'd4, val_of(5'd4), 0);
    offer(REQ_LSB, 5'd5, val_of(5'd5), 0);
    step();
    req_valid = '0;
    clear = 1'b1;
    offer(REQ_BR, 5'd6, val_of(5'd6), 0);
    #1 chk("flush_ready", 64'(req_ready), 64'(0));
    step();
    clear = 1'b0;
    req_valid = '0;
    expect_idle("flush_next");
    for (int i = 0; i < 3; i++) begin
      step();
      expect_idle("flush_quiet");
    end
    // Pointer was 1 before the flush; ALU winning over BR shows it is 0 now.
    offer(REQ_ALU, 5'd42, val_of(5'd42), 1);
    offer(REQ_BR,  5'd43, val_of(5'd43), 1);
    step();
    req_valid = '0;
    step();
    expect_bcast("flush_ptr_alu");
    step();
    expect_bcast("flush_ptr_br");
    step();
    expect_idle("flush_ptr_idle");

    // Pause for three edges while tag 7 is on the bus.
    offer(REQ_ALU, 5'd7,  val_of(5'd7),  1);
    offer(REQ_LSB, 5'd50, val_of(5'd50), 1);
    step();
    req_valid = '0;
    step();
    expect_bcast("pause_tag7");
    rdy = 1'b0;
    offer(REQ_BR, 5'd51, val_of(5'd51), 0);
    #1 chk("pause_ready", 64'(req_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_rdy", 64'(cdb_ready), 64'(1));
      chk("pause_id", 64'(cdb_rob_id), 64'(7));
      chk("pause_val", 64'(cdb_value), 64'(val_of(5'd7)));
    end
    rdy = 1'b1;
    req_valid = '0;
    step();
    expect_bcast("resume_lsb");
    step();
    expect_idle("resume_idle");

    // Reset with two slots occupied: nothing from them ever appears.
    offer(REQ_ALU, 5'd60, val_of(5'd60), 0);
    offer(REQ_BR,  5'd61, val_of(5'd61), 0);
    step();
    req_valid = '0;
    rst = 1'b1;
    #1 chk("mid_rst_ready", 64'(req_ready), 64'(0));
    step();
    chk("mid_rst_rdy", 64'(cdb_ready), 64'(0));
    chk("mid_rst_id", 64'(cdb_rob_id), 64'(0));
    chk("mid_rst_val", 64'(cdb_value), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_idle("mid_rst_quiet");
    end

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
